mem_bank: RTL and testbench
===========================

MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  request strobe, accepted only when ready=1.
REQ-006 SHALL have port write  input  1  1=write, 0=read; sampled with req.
REQ-007 SHALL have port address  input  ADDR_W  word address.
REQ-008 SHALL have port in_data  input  DATA_W  write data.
REQ-009 SHALL have port clear  input  1  one-cycle command to zero the whole array.
REQ-010 SHALL have port ready  output  1  block accepts requests.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse marking out_data valid.
REQ-012 SHALL have port out_data  output  DATA_W  registered read data.
REQ-013 SHALL have port parity_err  output  1  read parity mismatch; present only with MEM_PARITY_EN.

Function
REQ-014 SHALL implement a state machine with states CLEAR and RUN.
REQ-015 In CLEAR: counter from 0 writes zero to one word per cycle; ready=0; after writing DEPTH-1, next state RUN (DEPTH cycles total).
REQ-016 In RUN: ready=1; clear=1 -> state CLEAR with counter 0 on next edge.
REQ-017 clear and req in same RUN cycle: clear wins, request dropped, no out_valid.
REQ-018 clear asserted during CLEAR: sweep restarts at counter 0.
REQ-019 req while ready=0: ignored, memory unchanged, no response.
REQ-020 Accepted write: mem[address] updated at that rising edge; out_valid stays 0.
REQ-021 Accepted read: out_data = mem[address] and out_valid=1 on the following cycle (latency 1); one request per cycle, back-to-back reads at full rate.
REQ-022 Read accepted the cycle after a write to same address SHALL return the new data.
REQ-023 out_data SHALL hold its last value when out_valid=0.
REQ-024 Stored word width SHALL be exactly DATA_W (plus parity bit when enabled); address fully decodes, no wrap or aliasing.

Reset
REQ-025 reset_n=0 SHALL immediately force state CLEAR, counter 0, ready=0, out_valid=0, out_data=0, parity_err=0.
REQ-026 Reset mid-sweep or mid-RUN SHALL restart the sweep from address 0 after release; array contents otherwise not reset.

Configuration
REQ-027 With macro MEM_PARITY_EN defined: each word stores an extra even-parity bit computed from in_data (zero-sweep writes parity 0); on a read, parity_err=1 in the out_valid cycle iff recomputed parity differs from stored bit, else 0.
REQ-028 Without MEM_PARITY_EN: no parity storage, no parity_err port; all other behaviour identical.

Structure
REQ-029 Shared package mem_pkg SHALL hold the state typedef (CLEAR, RUN) and default DATA_W/ADDR_W constants.
REQ-030 Clear counter and CLEAR/RUN FSM SHALL live in sub-module mem_clear_seq, outputting sweep address, sweep write enable and ready.

Verification
REQ-031 Reset release, DATA_W=32, ADDR_W=12 -> ready=0 for exactly 4096 cycles, then 1; read of address 0xFFF returns 0x00000000 with out_valid one cycle later.
REQ-032 Write 0xDEADBEEF @0x005, next cycle read @0x005 -> out_data=0xDEADBEEF, out_valid=1 one cycle after read.
REQ-033 Back-to-back reads @0x001, @0x002 after writes 0x11, 0x22 -> out_valid high two consecutive cycles, data 0x11 then 0x22.
REQ-034 clear and read @0x005 in same cycle -> no out_valid, ready=0 for 4096 cycles, then read @0x005 returns 0.
REQ-035 reset_n pulsed low at sweep counter 100 -> outputs zeroed immediately, ready low a full 4096 cycles after release.
REQ-036 MEM_PARITY_EN: force stored parity bit @0x010 inverted after writing 0x1, read @0x010 -> parity_err=1 with out_valid; unforced read @0x011 -> parity_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_bank slice: sweep/run state type and
// default geometry constants.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 12;

  // CLEAR: zero sweep in progress, requests refused. RUN: normal service.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage : mem_pkg

// File: rtl/mem_clear_seq.sv
// Zero-sweep sequencer for mem_bank: owns the CLEAR/RUN state machine and
// the sweep counter, and tells the array which word to zero this cycle.
module mem_clear_seq
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;

  // State and sweep counter registers; reset always restarts the sweep at 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: a clear command restarts the sweep from any state.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      CLEAR: begin
        if (clear) begin
          cnt_next = '0;
        end else if (cnt == LAST_ADDR) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign sweep_addr = cnt;
  assign sweep_we   = (state == CLEAR);
  assign ready      = (state == RUN);

endmodule : mem_clear_seq

// File: rtl/mem_bank.sv
// Single-port word memory with a self-clearing zero sweep after reset or on
// a clear command, and a one-cycle registered read path.
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per word
// and report read parity mismatches on parity_err.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              wr_acc;
  logic              rd_acc;

  mem_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .sweep_addr (sweep_addr),
    .sweep_we   (sweep_we),
    .ready      (ready)
  );

  // A clear in the same cycle as a request wins and drops the request.
  assign wr_acc = req & ready & ~clear & write;
  assign rd_acc = req & ready & ~clear & ~write;

  // Array write port: the zero sweep and accepted writes never overlap,
  // since requests are only accepted outside the sweep.
  // NOTE: the array has no reset; it is zeroed by the sweep instead, which
  // keeps it mappable onto plain RAM.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[sweep_addr]     <= '0;
`ifdef MEM_PARITY_EN
      par_mem[sweep_addr] <= 1'b0;
`endif
    end else if (wr_acc) begin
      mem[address]        <= in_data;
`ifdef MEM_PARITY_EN
      par_mem[address]    <= ^in_data;
`endif
    end
  end

  // Registered read path: out_data only moves on an accepted read and holds
  // otherwise; out_valid pulses for one cycle per read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
`ifdef MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      out_valid  <= rd_acc;
`ifdef MEM_PARITY_EN
      parity_err <= rd_acc & ((^mem[address]) != par_mem[address]);
`endif
      if (rd_acc) begin
        out_data <= mem[address];
      end
    end
  end

endmodule : mem_bank

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the memory and its sweep.
`timescale 1ns/1ps
module tb_mem_bank;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          req     = 1'b0;
  logic          write   = 1'b0;
  logic          clear   = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] in_data = '0;
  logic          ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
`ifdef MEM_PARITY_EN
  logic          parity_err;
`endif

  mem_bank #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .write      (write),
    .address    (address),
    .in_data    (in_data),
    .clear      (clear),
    .ready      (ready),
    .out_valid  (out_valid),
    .out_data   (out_data)
`ifdef MEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sweep_left counts the cycles of zero sweep still owed; the block is
  // ready exactly when nothing is owed.
  bit [DW-1:0] m_mem  [DEPTH];
  bit          m_flip [DEPTH];
  int          sweep_left = DEPTH;
  int          m_idx;
  bit          m_busy;
  bit          e_valid = 1'b0;
  bit [DW-1:0] e_data  = '0;
  bit          e_perr  = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_left = DEPTH;
      e_valid    = 1'b0;
      e_data     = '0;
      e_perr     = 1'b0;
    end else begin
      m_busy  = (sweep_left != 0);
      e_valid = 1'b0;
      e_perr  = 1'b0;
      if (m_busy) begin
        m_idx         = DEPTH - sweep_left;
        m_mem[m_idx]  = '0;
        m_flip[m_idx] = 1'b0;
      end
      if (clear) begin
        sweep_left = DEPTH;
      end else if (m_busy) begin
        sweep_left = sweep_left - 1;
      end else if (req) begin
        if (write) begin
          m_mem[address]  = in_data;
          m_flip[address] = 1'b0;
        end else begin
          e_valid = 1'b1;
          e_data  = m_mem[address];
          e_perr  = m_flip[address];
        end
      end
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      check("ready", ready, sweep_left == 0);
      check("out_valid", out_valid, e_valid);
      check("out_data", out_data, e_data);
`ifdef MEM_PARITY_EN
      if (e_valid) check("parity_err", parity_err, e_perr);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input bit c);
    @(negedge clock);
    req     = r;
    write   = w;
    address = a;
    in_data = d;
    clear   = c;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Counts cycles with ready low, the current cycle included; bounded.
  task automatic wait_ready(output int n);
    n = 1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      @(negedge clock);
      if (ready) break;
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit r, w, c;
    logic [AW-1:0] a;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    reset_n = 1'b1;
    wait_ready(n);
    check("initial_sweep_len", n, DEPTH);

    // Top word reads back as zero after the sweep
    cyc(1'b1, 1'b0, 12'hFFF, '0, 1'b0);
    idle();
    check("rd_fff_valid", out_valid, 1'b1);
    check("rd_fff_data", out_data, 32'h0);

    // Write then immediate read of the same address
    cyc(1'b1, 1'b1, 12'h005, 32'hDEADBEEF, 1'b0);
    cyc(1'b1, 1'b0, 12'h005, '0, 1'b0);
    idle();
    check("raw_valid", out_valid, 1'b1);
    check("raw_data", out_data, 32'hDEADBEEF);

    // Back-to-back reads at full rate, then data holds
    cyc(1'b1, 1'b1, 12'h001, 32'h11, 1'b0);
    cyc(1'b1, 1'b1, 12'h002, 32'h22, 1'b0);
    cyc(1'b1, 1'b0, 12'h001, '0, 1'b0);
    cyc(1'b1, 1'b0, 12'h002, '0, 1'b0);
    check("b2b_0_valid", out_valid, 1'b1);
    check("b2b_0_data", out_data, 32'h11);
    idle();
    check("b2b_1_valid", out_valid, 1'b1);
    check("b2b_1_data", out_data, 32'h22);
    idle();
    check("hold_valid", out_valid, 1'b0);
    check("hold_data", out_data, 32'h22);

    // Clear wins over a same-cycle read
    cyc(1'b1, 1'b0, 12'h005, '0, 1'b1);
    idle();
    check("clr_rd_no_valid", out_valid, 1'b0);
    check("clr_ready_low", ready, 1'b0);
    wait_ready(n);
    check("clear_sweep_len", n, DEPTH);
    cyc(1'b1, 1'b0, 12'h005, '0, 1'b0);
    idle();
    check("after_clr_valid", out_valid, 1'b1);
    check("after_clr_data", out_data, 32'h0);

`ifdef MEM_PARITY_EN
    // Corrupt one stored parity bit and read both it and a clean neighbour
    cyc(1'b1, 1'b1, 12'h010, 32'h1, 1'b0);
    cyc(1'b1, 1'b1, 12'h011, 32'h1, 1'b0);
    idle();
    dut.par_mem[16] = ~dut.par_mem[16];
    m_flip[16] = 1'b1;
    cyc(1'b1, 1'b0, 12'h010, '0, 1'b0);
    cyc(1'b1, 1'b0, 12'h011, '0, 1'b0);
    check("par_bad_valid", out_valid, 1'b1);
    check("par_bad_err", parity_err, 1'b1);
    idle();
    check("par_good_valid", out_valid, 1'b1);
    check("par_good_err", parity_err, 1'b0);
`endif

    // Randomized traffic, including requests during sweeps and rare clears
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) != 0;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      c = ($urandom_range(0, 599) == 0);
      cyc(r, w, a, $urandom, c);
    end
    idle();
    wait_ready(n);

    // Reset part-way into a sweep: outputs drop at once, sweep restarts
    cyc(1'b1, 1'b1, 12'h007, 32'hA5A5A5A5, 1'b0);
    cyc(1'b1, 1'b0, 12'h007, '0, 1'b0);
    idle();
    check("pre_rst_data", out_data, 32'hA5A5A5A5);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    repeat (100) idle();
    reset_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n);
    check("post_rst_sweep_len", n, DEPTH);
    cyc(1'b1, 1'b0, 12'h007, '0, 1'b0);
    idle();
    check("post_rst_rd_valid", out_valid, 1'b1);
    check("post_rst_rd_data", out_data, 32'h0);

    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_bank
